// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: state encoding, opcodes, IR field positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } state_t;

    localparam logic [1:0] OP_JMP = 2'b11;

    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 6;
    localparam int RS_MSB  = 5;
    localparam int RS_LSB  = 4;
    localparam int RT_MSB  = 3;
    localparam int RT_LSB  = 2;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

endpackage

// File: rtl/instr_sequencer_if.sv
// Sequencer bus bundle: imem req/ack fetch port, decoded IR fields, control strobes and status.
// Latency: n/a (wiring only).
// Backpressure: imem_req is held until imem_ack; nothing else is flow controlled.
interface instr_sequencer_if #(parameter int PC_W = 4);
    logic            start;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [7:0]      imem_data;
    logic [1:0]      op;
    logic [1:0]      rs;
    logic [1:0]      rt;
    logic [3:0]      imm;
    logic            exec_en;
    logic            br_taken;
    logic            busy;
    logic            halted;

    modport master (
        input  start, imem_ack, imem_data, br_taken,
        output imem_req, imem_addr, op, rs, rt, imm, exec_en, busy, halted
    );

    modport slave (
        output start, imem_ack, imem_data, br_taken,
        input  imem_req, imem_addr, op, rs, rt, imm, exec_en, busy, halted
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter: clear to zero, sequential increment, or relative jump by sign-extended imm.
// Latency: new pc visible the cycle after advance/load_zero.
// Backpressure: none; updates only when told to.
module pc_unit #(
    parameter int PC_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_zero,
    input  logic            advance,
    input  logic            take_jump,
    input  logic [3:0]      imm,
    output logic [PC_W-1:0] pc
);
    logic signed [3:0] imm_s;
    logic [PC_W-1:0]   offset;
    logic [PC_W-1:0]   pc_q;

    // signed source makes the size cast sign-extend; the sum wraps at PC_W bits
    assign imm_s  = imm;
    assign offset = take_jump ? PC_W'(imm_s) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else if (load_zero) begin
            pc_q <= '0;
        end else if (advance) begin
            pc_q <= pc_q + PC_W'(1) + offset;
        end
    end

    assign pc = pc_q;
endmodule

// File: rtl/instr_sequencer.sv
// Fetch/sequence stage: fetches 8-bit instructions, holds IR, strobes exec_en once per instruction.
// Latency: 3 cycles per instruction plus one per imem wait cycle; SEQ_SINGLE_STEP_EN gates DECODE on step.
// Backpressure: FETCH holds imem_req/imem_addr stable until imem_ack; acks outside FETCH are dropped.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int         PC_W      = 4,
    parameter logic [7:0] HALT_WORD = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                  step,
`endif
    instr_sequencer_if.master     bus
);
    state_t          state;
    state_t          state_nxt;
    logic [7:0]      ir;
    logic [PC_W-1:0] pc;
    logic            load_zero;
    logic            advance;
    logic            take_jump;
    logic            step_ok;

`ifdef SEQ_SINGLE_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir <= 8'h00;
        end else if (state == FETCH && bus.imem_ack) begin
            ir <= bus.imem_data;
        end
    end

    always_comb begin
        state_nxt = state;
        load_zero = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = FETCH;
                    load_zero = 1'b1;
                end
            end
            FETCH: begin
                if (bus.imem_ack) state_nxt = DECODE;
            end
            DECODE: begin
                // halt check wins over step so a halt word never waits for a release
                if (ir == HALT_WORD)  state_nxt = HALT;
                else if (step_ok)     state_nxt = EXEC;
            end
            EXEC: begin
                state_nxt = FETCH;
            end
            HALT: begin
                if (bus.start) begin
                    state_nxt = FETCH;
                    load_zero = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign advance   = (state == EXEC);
    assign take_jump = advance && (ir[OP_MSB:OP_LSB] == OP_JMP) && bus.br_taken;

    pc_unit #(.PC_W(PC_W)) u_pc_unit (
        .clk       (clk),
        .rst       (rst),
        .load_zero (load_zero),
        .advance   (advance),
        .take_jump (take_jump),
        .imm       (ir[IMM_MSB:IMM_LSB]),
        .pc        (pc)
    );

    assign bus.imem_req  = (state == FETCH);
    assign bus.imem_addr = pc;
    assign bus.op        = ir[OP_MSB:OP_LSB];
    assign bus.rs        = ir[RS_MSB:RS_LSB];
    assign bus.rt        = ir[RT_MSB:RT_LSB];
    assign bus.imm       = ir[IMM_MSB:IMM_LSB];
    assign bus.exec_en   = (state == EXEC);
    assign bus.busy      = (state == FETCH) || (state == DECODE) || (state == EXEC);
    assign bus.halted    = (state == HALT);
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Fetch/sequence stage directly upstream of the control decoder.
- Holds the program counter and fetches 8-bit instructions from instruction memory over a req/ack handshake.
- Latches each instruction into an instruction register and presents its 2-bit opcode plus operand fields to the decoder and datapath.
- Emits a one-cycle execute strobe per instruction and resolves conditional jumps from a datapath flag.

Parameters:
- PC_W, 4: program counter and instruction address width; wraps modulo 2^PC_W.
- HALT_WORD, 8'hFF: instruction encoding that stops sequencing. It is detected in DECODE and never executed.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level; leaves IDLE or HALT and begins sequencing from PC 0.
- imem_req  out  1  fetch request, held high until acknowledged.
- imem_addr  out  PC_W  fetch address; equals the PC while imem_req is high.
- imem_ack  in  1  one-cycle acknowledge; imem_data is valid in the same cycle.
- imem_data  in  8  instruction word.
- op  out  2  IR[7:6]; drives the control decoder input.
- rs  out  2  IR[5:4].
- rt  out  2  IR[3:2].
- imm  out  4  IR[3:0]; jump offset, two's complement.
- exec_en  out  1  one-cycle strobe; the datapath commits its control word only in this cycle.
- br_taken  in  1  datapath condition flag, sampled only in EXEC when op==2'b11.
- busy  out  1  high in FETCH, DECODE and EXEC.
- halted  out  1  high in HALT.

Behaviour:
- Reset values: pc=0, IR=8'h00 (so op=2'b00), imem_req=0, exec_en=0, busy=0, halted=0, state=IDLE.
- States: IDLE, FETCH, DECODE, EXEC, HALT. Encoding comes from the shared package.
- IDLE: start=1 moves to FETCH with pc=0.
- FETCH: imem_req=1 and imem_addr=pc.
  - On imem_ack: IR<=imem_data, then go to DECODE.
  - Without ack, stay indefinitely with the request held stable.
- DECODE: one settle cycle for the combinational decoder; exec_en=0.
  - If IR==HALT_WORD, go to HALT. pc is unchanged and points at the halt word.
  - Otherwise go to EXEC.
- EXEC: exec_en=1 for exactly one cycle, then go to FETCH.
  - op==2'b11 and br_taken=1: pc <= pc + 1 + sext(imm).
  - All other cases: pc <= pc + 1.
  - Arithmetic is PC_W bits and wraps. Example: pc=4'hF with no jump gives 4'h0; pc=4'h0 with imm=4'hE and a taken jump gives 4'hF.
- Latency: 3 cycles per instruction with zero-wait memory (FETCH with ack in the same cycle, then DECODE, then EXEC). Each imem wait cycle adds one.
- HALT: halted=1, busy=0, IR retained.
  - start=1 restarts: pc<=0, go to FETCH.
- start is ignored while busy.
- imem_ack outside FETCH is ignored, with no IR change.
- op/rs/rt/imm change only when IR is loaded. They are stable from DECODE through EXEC.
- rst in any state, including mid-fetch, takes effect next edge. imem_req drops immediately after the reset edge; any acknowledge arriving afterwards is ignored.

Optional Feature:
- Macro SEQ_SINGLE_STEP_EN adds input step (1 bit).
- With it: DECODE holds until step==1, and still checks HALT_WORD first. Each step pulse releases exactly one instruction. A step held high releases one instruction per pass through DECODE.
- Without it: no step port; DECODE always lasts exactly one cycle.

Decomposition:
- Shared package (seq_pkg):
  - state encoding localparams: IDLE=3'd0, FETCH=3'd1, DECODE=3'd2, EXEC=3'd3, HALT=3'd4
  - OP_JMP=2'b11
  - instruction field bit positions
- One sub-module is natural: pc_unit. It holds the PC register, the increment, the sign-extended jump adder and wrap. Its inputs are load_zero, advance, take_jump and imm.
- The FSM and IR stay in instr_sequencer.

Test Plan:
- Reset then idle: hold rst 2 cycles with start=0 -> op=2'b00, imem_req=0, busy=0, halted=0, pc stays 0 for 10 cycles.
- Straight-line program: ROM {8'h01, 8'h45, 8'h82, 8'hFF}, ack same cycle, start pulse -> addrs 0,1,2,3 fetched; op sequence 00,01,10; exactly 3 exec_en pulses spaced 3 cycles apart; halted=1 with pc=3.
- Memory wait states: ack delayed 2 cycles on every fetch -> imem_req and imem_addr stable throughout the wait; 5 cycles per instruction; no exec_en during the wait.
- Jump: at addr 2 place 8'hCE (op 11, imm -2) with br_taken=1 -> next fetch addr 1. Repeat with br_taken=0 -> next fetch addr 3. Also pc=4'hF sequential -> next fetch addr 0.
- Reset mid-fetch: assert rst while imem_req=1 and waiting, ack arrives one cycle later -> imem_req=0 after the reset edge, IR stays 8'h00, state IDLE.
- Single step (SEQ_SINGLE_STEP_EN): step pulses at cycles 20 and 40 -> exactly one exec_en after each pulse; DECODE holds between them with op stable.
